// File: rtl/seg7_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared types and constants for the seven-segment frame reader
//               (FSM states, error codes, active-low segment glyphs, limits).
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Frame reader states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Error causes reported on err_code
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_BAD   = 2'b01;
  localparam logic [1:0] ERR_SEQ   = 2'b10;
  localparam logic [1:0] ERR_RANGE = 2'b11;

  // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Accumulator width and largest value the display path can render
  localparam int               ACC_W     = 20;
  localparam logic [ACC_W-1:0] MAX_VALUE = 20'd131071;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seg7_pattern_decode
// Description : Combinational decode of one active-low segment pattern into a
//               decimal digit; blank reads as 0, anything else is flagged bad.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       bad
);

  // Pattern lookup; unrecognised glyphs (including A-F) raise bad
  always_comb begin
    digit = 4'd0;
    bad   = 1'b0;
    case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: digit = 4'd0;
      default:   bad   = 1'b1;
    endcase
  end

endmodule : seg7_pattern_decode
`default_nettype wire

// File: rtl/seg7_frame_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seg7_frame_reader
// Description : Collects six strobed seven-segment digits, decodes them and
//               rebuilds the binary value shown on the display, with a
//               valid/ready result handshake and one-cycle error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_frame_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int VAL_W      = 17
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              seg_in,
  input  logic [2:0]              digit_sel,
  input  logic                    seg_strobe,
  output logic [VAL_W-1:0]        out_value,
  output logic [4*NUM_DIGITS-1:0] out_digits,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_pulse,
  output logic [1:0]              err_code
);

  state_t                  state_q, state_d;
  logic [2:0]              exp_idx_q, exp_idx_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [ACC_W-1:0]        weight_q, weight_d;
  logic [4*NUM_DIGITS-1:0] work_digits_q, work_digits_d;
  logic [4*NUM_DIGITS-1:0] res_digits_q, res_digits_d;
  logic [VAL_W-1:0]        value_q, value_d;
  logic                    err_pulse_q, err_pulse_d;
  logic [1:0]              err_code_q, err_code_d;

  logic [3:0]              dec_digit;
  logic                    dec_bad;
  logic [ACC_W-1:0]        term;
  logic [ACC_W-1:0]        sum;
  logic [ACC_W-1:0]        weight_x10;
  logic [4*NUM_DIGITS-1:0] digits_upd;

  seg7_pattern_decode u_decode (
    .seg   (seg_in),
    .digit (dec_digit),
    .bad   (dec_bad)
  );

  // Datapath helpers: running sum with this digit, next weight (x8 + x2),
  // and the digit vector with the incoming nibble dropped into place
  always_comb begin
    term       = ACC_W'(dec_digit) * weight_q;
    sum        = acc_q + term;
    weight_x10 = (weight_q << 3) + (weight_q << 1);
    digits_upd = work_digits_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_sel == 3'(i)) digits_upd[4*i +: 4] = dec_digit;
    end
  end

  // Frame sequencing, accumulation, completion range check and handshake
  always_comb begin
    state_d       = state_q;
    exp_idx_d     = exp_idx_q;
    acc_d         = acc_q;
    weight_d      = weight_q;
    work_digits_d = work_digits_q;
    res_digits_d  = res_digits_q;
    value_d       = value_q;
    err_pulse_d   = 1'b0;
    err_code_d    = ERR_NONE;

    case (state_q)
      IDLE: begin
        if (seg_strobe) begin
          if (digit_sel != 3'd0) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_SEQ;
          end else if (dec_bad) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_BAD;
          end else begin
            state_d       = COLLECT;
            exp_idx_d     = 3'd1;
            acc_d         = ACC_W'(dec_digit);
            weight_d      = ACC_W'(10);
            work_digits_d = {{(4*NUM_DIGITS-4){1'b0}}, dec_digit};
          end
        end
      end

      COLLECT: begin
        if (seg_strobe) begin
          if (digit_sel == exp_idx_q) begin
            if (dec_bad) begin
              state_d     = IDLE;
              err_pulse_d = 1'b1;
              err_code_d  = ERR_BAD;
            end else begin
              acc_d         = sum;
              weight_d      = weight_x10;
              work_digits_d = digits_upd;
              exp_idx_d     = exp_idx_q + 3'd1;
              if (exp_idx_q == 3'(NUM_DIGITS - 1)) begin
                if (sum > MAX_VALUE) begin
                  state_d     = IDLE;
                  err_pulse_d = 1'b1;
                  err_code_d  = ERR_RANGE;
                end else begin
                  state_d      = HOLD;
                  value_d      = sum[VAL_W-1:0];
                  res_digits_d = digits_upd;
                end
              end
            end
          end else if (digit_sel == 3'd0) begin
            // Early index 0: treat it as the start of a fresh frame
            err_pulse_d = 1'b1;
            err_code_d  = ERR_SEQ;
            if (dec_bad) begin
              state_d = IDLE;
            end else begin
              exp_idx_d     = 3'd1;
              acc_d         = ACC_W'(dec_digit);
              weight_d      = ACC_W'(10);
              work_digits_d = {{(4*NUM_DIGITS-4){1'b0}}, dec_digit};
            end
          end else begin
            state_d     = IDLE;
            err_pulse_d = 1'b1;
            err_code_d  = ERR_SEQ;
          end
        end
      end

      HOLD: begin
        // Strobes are ignored here; only the consumer handshake leaves HOLD
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and result registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      exp_idx_q     <= 3'd0;
      acc_q         <= '0;
      weight_q      <= ACC_W'(1);
      work_digits_q <= '0;
      res_digits_q  <= '0;
      value_q       <= '0;
      err_pulse_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      exp_idx_q     <= exp_idx_d;
      acc_q         <= acc_d;
      weight_q      <= weight_d;
      work_digits_q <= work_digits_d;
      res_digits_q  <= res_digits_d;
      value_q       <= value_d;
      err_pulse_q   <= err_pulse_d;
      err_code_q    <= err_code_d;
    end
  end

  assign out_valid  = (state_q == HOLD);
  assign out_value  = value_q;
  assign out_digits = res_digits_q;
  assign err_pulse  = err_pulse_q;
  assign err_code   = err_code_q;

endmodule : seg7_frame_reader
`default_nettype wire

// File: tb/tb_seg7_frame_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_seg7_frame_reader
// Description : Directed-vector bench with an expected-response queue; a
//               negedge monitor pops and compares results and error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_frame_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  seg_in;
  logic [2:0]  digit_sel;
  logic        seg_strobe;
  logic [16:0] out_value;
  logic [23:0] out_digits;
  logic        out_valid;
  logic        out_ready;
  logic        err_pulse;
  logic [1:0]  err_code;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [16:0] val;
    logic [23:0] dig;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          prev_valid = 1'b0;
  logic [16:0] held_val;
  logic [23:0] held_dig;

  always #5 clk = ~clk;

  seg7_frame_reader #(.NUM_DIGITS(6), .VAL_W(17)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .seg_in     (seg_in),
    .digit_sel  (digit_sel),
    .seg_strobe (seg_strobe),
    .out_value  (out_value),
    .out_digits (out_digits),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_pulse  (err_pulse),
    .err_code   (err_code)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Hand-written glyph table; nibble 0xB encodes a blank, 0xA the A glyph
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      4'hB:    return 7'h7F;
      default: return 7'h08;
    endcase
  endfunction

  task automatic push_res(input logic [16:0] v, input logic [23:0] d);
    exp_t e;
    e.is_err = 1'b0; e.code = 2'b00; e.val = v; e.dig = d;
    sbq.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] c);
    exp_t e;
    e.is_err = 1'b1; e.code = c; e.val = '0; e.dig = '0;
    sbq.push_back(e);
  endtask

  // One strobe; entered and left at 1 time unit after a rising edge
  task automatic strobe(input logic [2:0] idx, input logic [6:0] p);
    seg_in     = p;
    digit_sel  = idx;
    seg_strobe = 1'b1;
    @(posedge clk); #1;
    seg_strobe = 1'b0;
    seg_in     = 7'h7F;
    digit_sel  = 3'd0;
  endtask

  task automatic frame(input logic [23:0] nib);
    for (int i = 0; i < 6; i++) strobe(3'(i), seg_of(nib[4*i +: 4]));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every error pulse and every accepted result in order,
  // and checks that a pending result does not change while it waits
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && prev_valid) begin
        check("hold_value_stable", 32'(out_value), 32'(held_val));
        check("hold_digits_stable", 32'(out_digits), 32'(held_dig));
      end
      if (err_pulse) begin
        if (sbq.size() == 0) begin
          check("unexpected_err_pulse", 32'(err_code), 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          check("err_is_expected_kind", 32'(e.is_err), 32'd1);
          check("err_code", 32'(err_code), 32'(e.code));
        end
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_result", 32'(out_value), 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          check("result_is_expected_kind", 32'(e.is_err), 32'd0);
          check("out_value", 32'(out_value), 32'(e.val));
          check("out_digits", 32'(out_digits), 32'(e.dig));
        end
      end
      if (out_valid && !prev_valid) begin
        held_val = out_value;
        held_dig = out_digits;
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    seg_in     = 7'h7F;
    digit_sel  = 3'd0;
    seg_strobe = 1'b0;
    out_ready  = 1'b1;
    #2;
    check("rst_out_value", 32'(out_value), 32'd0);
    check("rst_out_digits", 32'(out_digits), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(2);

    // Largest legal value, consumer always ready
    push_res(17'd131071, 24'h131071);
    frame(24'h131071);
    idle(3);

    // One past the limit: range error, no result
    push_err(2'b11);
    frame(24'h131072);
    idle(3);

    // Frame starting at index 2, then a clean 42 with blank upper digits
    push_err(2'b10);
    strobe(3'd2, seg_of(4'd5));
    idle(2);
    push_res(17'd42, 24'h000042);
    frame(24'hBBBB42);
    idle(3);

    // A glyph at digit 3, then a clean frame
    strobe(3'd0, seg_of(4'd1));
    strobe(3'd1, seg_of(4'd2));
    strobe(3'd2, seg_of(4'd3));
    push_err(2'b01);
    strobe(3'd3, seg_of(4'hA));
    idle(2);
    push_res(17'd98765, 24'h098765);
    frame(24'h098765);
    idle(3);

    // Early index 0 mid-frame restarts from that digit
    strobe(3'd0, seg_of(4'd3));
    strobe(3'd1, seg_of(4'd4));
    push_err(2'b10);
    strobe(3'd0, seg_of(4'd5));
    strobe(3'd1, seg_of(4'd0));
    strobe(3'd2, seg_of(4'd0));
    strobe(3'd3, seg_of(4'd0));
    strobe(3'd4, seg_of(4'd0));
    push_res(17'd100005, 24'h100005);
    strobe(3'd5, seg_of(4'd1));
    idle(3);

    // Index 7 mid-frame drops to IDLE; a following index 1 is also rejected
    strobe(3'd0, seg_of(4'd1));
    push_err(2'b10);
    strobe(3'd7, seg_of(4'd1));
    push_err(2'b10);
    strobe(3'd1, seg_of(4'd2));
    idle(3);

    // Result held with consumer stalled while a second frame is ignored
    out_ready = 1'b0;
    push_res(17'd12345, 24'h012345);
    frame(24'h012345);
    frame(24'h054321);
    idle(4);
    out_ready = 1'b1;
    idle(3);

    // Reset after digit 3, then a clean 999
    strobe(3'd0, seg_of(4'd6));
    strobe(3'd1, seg_of(4'd5));
    strobe(3'd2, seg_of(4'd4));
    strobe(3'd3, seg_of(4'd3));
    reset_n = 1'b0;
    #1;
    check("midrst_out_value", 32'(out_value), 32'd0);
    check("midrst_out_digits", 32'(out_digits), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_err_pulse", 32'(err_pulse), 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    push_res(17'd999, 24'h000999);
    frame(24'hBBB999);
    idle(3);

    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(posedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_seg7_frame_reader
`default_nettype wire

// File: doc/seg7_frame_reader.md
# seg7_frame_reader

Receive-side block for the time-multiplexed seven-segment bus. It samples one active-low segment pattern per strobe, tagged with a digit index 0–5, and decodes each pattern back to a decimal digit. Once a full six-digit frame has arrived, it reassembles the 17-bit binary value that the display path rendered. Bench and loopback logic use it to read the displayed number back, so it sits opposite the switch-to-display datapath.

## Interface
Parameters:
- `NUM_DIGITS`, default 6: digits per frame. Fixed at 6; the range check below depends on it.
- `VAL_W`, default 17: width of the reconstructed value.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `seg_in`, input, 7: segment pattern. Bit 0 = segment a … bit 6 = segment g. A 0 means the segment is lit.
- `digit_sel`, input, 3: digit index of `seg_in`. 0 is the least significant digit.
- `seg_strobe`, input, 1: one-cycle qualifier. `seg_in` and `digit_sel` are valid only when this is high.
- `out_value`, output, 17: reconstructed binary value.
- `out_digits`, output, 24: decoded digits, with digit i at bits [4i+3:4i].
- `out_valid`, output, 1: result available. Held high until accepted.
- `out_ready`, input, 1: consumer accepts the result when `out_valid` and `out_ready` are both high.
- `err_pulse`, output, 1: one-cycle error indication.
- `err_code`, output, 2: error cause, valid while `err_pulse` is high. 01 = bad pattern, 10 = sequence, 11 = range.

## Operation
Segment patterns accepted (a..g order is bit0..bit6; values written MSB = g):
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
- 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Blank (1111111) decodes as digit 0.
- Any other pattern is a bad pattern, including the A–F glyphs.

States and transitions:
- **IDLE**: waiting for the start of a frame. A strobe with `digit_sel` = 0 captures digit 0 and moves to COLLECT with the expected index set to 1. Any other strobe raises a sequence error and the block stays in IDLE.
- **COLLECT**: a strobe whose index equals the expected index is accepted, and the expected index increments.
  - A strobe with index 0 raises a sequence error and restarts the frame using that digit.
  - Any other index, including 6 and 7, raises a sequence error and returns to IDLE.
  - A bad pattern raises err 01 and returns to IDLE.
- **Completion**: accepting digit 5 completes the frame.
  - If the value is ≤ 131071, the block moves to HOLD.
  - Otherwise it raises err 11 and returns to IDLE.
- **HOLD**: `out_valid` = 1 and all strobes are ignored, including a strobe in the handshake cycle. On `out_valid && out_ready` the block returns to IDLE.

Arithmetic:
- A 20-bit accumulator adds digit × weight for each accepted digit.
- The weight register is 20 bits, starts at 1, and is multiplied by 10 after each digit using shift-add (×8 + ×2).
- The range check uses the full 20-bit sum. `out_value` is the low 17 bits.

## Timing
- Reset values: `out_value` = 0, `out_digits` = 0, `out_valid` = 0, `err_pulse` = 0, `err_code` = 0, state IDLE, accumulator 0, weight 1.
- `out_valid` rises the cycle after the strobe that carried digit 5. Latency is 1 cycle.
- `out_value` and `out_digits` are stable for as long as `out_valid` is high.
- `err_pulse` rises the cycle after the offending strobe and lasts exactly 1 cycle.
- Back-to-back strobes on consecutive cycles are supported. A 6-digit frame takes at least 6 cycles.
- If `reset_n` is asserted mid-frame or in HOLD, all outputs and state return to their reset values immediately. No partial result is emitted.

## Structure
- Shared package `seg7_pkg`:
  - state enum `{IDLE, COLLECT, HOLD}`
  - `err_code` constants
  - segment-pattern constants for 0–9 and blank
  - `MAX_VALUE` = 131071
- Sub-module `seg7_pattern_decode`: purely combinational. Takes 7 bits and returns a 4-bit digit plus a `bad` flag.
- All sequencing, accumulation and the handshake live in the top module.

## Test plan
- Frame with digits 1,7,0,1,3,1 in order 0→5 and `out_ready` held high → `out_value` = 131071 and `out_digits` = 0x131071, with `out_valid` high for 1 cycle.
- Frame with digits 2,7,0,1,3,1 → value 131072 → `err_pulse` with code 11, `out_valid` stays 0.
- First strobe carries index 2 → err 10, block stays in IDLE. A following clean frame for 42 (2,4, then four blanks) → `out_value` = 42.
- Pattern 0001000 (A glyph) at digit 3 → err 01. The next clean frame decodes correctly.
- Result held with `out_ready` = 0 for 10 cycles while a second frame is strobed in → first value stays stable and the second frame is dropped. `out_ready` = 1 → one handshake, then IDLE.
- `reset_n` pulsed low after digit 3 → all outputs 0 on the next sample. A subsequent full frame for 999 → `out_value` = 999.
